// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: toggle-flag byte capture, FWFT read port,
// fill level and sticky overflow.
module uart_rx_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_toggle,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   input  logic              clear_overflow
);

   localparam int unsigned PTR_W = ADDR_W + 1;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W-1:0] wr_ptr_d, rd_ptr_d;
   logic             toggle_q, armed;
   logic             overflow_d;
   logic             push_evt, pop, full, push, drop;

   // Next-state: edge detect on the receiver flag, push/pop arbitration
   always_comb begin
      push_evt   = 1'b0;
      pop        = 1'b0;
      full       = 1'b0;
      push       = 1'b0;
      drop       = 1'b0;
      wr_ptr_d   = wr_ptr;
      rd_ptr_d   = rd_ptr;
      overflow_d = overflow;

      push_evt = armed & (rx_toggle != toggle_q);
      pop      = rd_valid & rd_ready;
      full     = (count == PTR_W'(DEPTH));
      // A pop in the same cycle frees the slot, so a full FIFO still accepts
      push     = push_evt & (~full | pop);
      drop     = push_evt & full & ~pop;

      wr_ptr_d = wr_ptr + PTR_W'(push);
      rd_ptr_d = rd_ptr + PTR_W'(pop);

      if (drop)
         overflow_d = 1'b1;
      else if (clear_overflow)
         overflow_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
         overflow <= 1'b0;
         toggle_q <= 1'b0;
         armed    <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_d;
         rd_ptr   <= rd_ptr_d;
         count    <= wr_ptr_d - rd_ptr_d;
         rd_valid <= (wr_ptr_d != rd_ptr_d);
         overflow <= overflow_d;
         toggle_q <= rx_toggle;
         armed    <= 1'b1;
      end
   end

   // Storage is not reset; pointers alone define what is valid
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[ADDR_W-1:0]] <= rx_data;
   end

   assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: toggle capture, FWFT ordering, overflow,
// async reset and pointer wrap.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_toggle;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic [4:0] count;
   logic       overflow;
   logic       clear_overflow;

   int checks   = 0;
   int failures = 0;

   uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_data        (rx_data),
      .rx_toggle      (rx_toggle),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .count          (count),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_data   = b;
      rx_toggle = ~rx_toggle;
      tick();
   endtask

   task automatic test_reset();
      #23;
      checks++;
      if (count !== 5'd0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: count=%0d rd_valid=%b overflow=%b, expected 0/0/0",
                  count, rd_valid, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (count !== 5'd0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL prime_no_push[%0d]: count=%0d rd_valid=%b, expected 0/0",
                     i, count, rd_valid);
         end
      end
      push_byte(8'h41);
      checks++;
      if (count !== 5'd1 || rd_valid !== 1'b1 || rd_data !== 8'h41) begin
         failures++;
         $display("FAIL first_byte: count=%0d rd_valid=%b rd_data=%h, expected 1/1/41",
                  count, rd_valid, rd_data);
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      checks++;
      if (count !== 5'd0 || rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL first_pop: count=%0d rd_valid=%b, expected 0/0", count, rd_valid);
      end
   endtask

   task automatic test_fwft_order();
      push_byte(8'h10);
      push_byte(8'h11);
      push_byte(8'h12);
      checks++;
      if (count !== 5'd3) begin
         failures++;
         $display("FAIL fwft_count: count=%0d, expected 3", count);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== 8'(8'h10 + i)) begin
            failures++;
            $display("FAIL fwft_read[%0d]: rd_valid=%b rd_data=%h, expected 1/%h",
                     i, rd_valid, rd_data, 8'(8'h10 + i));
         end
         tick();
      end
      rd_ready = 1'b0;
      checks++;
      if (count !== 5'd0 || rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL fwft_empty: count=%0d rd_valid=%b, expected 0/0", count, rd_valid);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 17; i++)
         push_byte(8'(i));
      checks++;
      if (count !== 5'd16 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL ovf_full: count=%0d overflow=%b, expected 16/1", count, overflow);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
            failures++;
            $display("FAIL ovf_drain[%0d]: rd_valid=%b rd_data=%h, expected 1/%h",
                     i, rd_valid, rd_data, 8'(i));
         end
         tick();
      end
      rd_ready = 1'b0;
      checks++;
      if (count !== 5'd0 || rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL ovf_lost: count=%0d rd_valid=%b, expected 0/0", count, rd_valid);
      end
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear: overflow=%b, expected 0", overflow);
      end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 16; i++)
         push_byte(8'(8'h20 + i));
      rd_ready = 1'b1;
      push_byte(8'hAA);
      rd_ready = 1'b0;
      checks++;
      if (count !== 5'd16 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL full_pushpop: count=%0d overflow=%b, expected 16/0", count, overflow);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         logic [7:0] exp_b;
         exp_b = (i == 15) ? 8'hAA : 8'(8'h21 + i);
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
            failures++;
            $display("FAIL full_drain[%0d]: rd_valid=%b rd_data=%h, expected 1/%h",
                     i, rd_valid, rd_data, exp_b);
         end
         tick();
      end
      rd_ready = 1'b0;
      checks++;
      if (count !== 5'd0) begin
         failures++;
         $display("FAIL full_empty: count=%0d, expected 0", count);
      end
   endtask

   task automatic test_clear_vs_drop();
      for (int i = 0; i < 16; i++)
         push_byte(8'(8'h30 + i));
      clear_overflow = 1'b1;
      push_byte(8'h99);
      clear_overflow = 1'b0;
      checks++;
      if (overflow !== 1'b1 || count !== 5'd16) begin
         failures++;
         $display("FAIL set_wins: overflow=%b count=%0d, expected 1/16", overflow, count);
      end
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         failures++;
         $display("FAIL clear_alone: overflow=%b, expected 0", overflow);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (rd_data !== 8'(8'h30 + i)) begin
            failures++;
            $display("FAIL clr_drain[%0d]: rd_data=%h, expected %h",
                     i, rd_data, 8'(8'h30 + i));
         end
         tick();
      end
      rd_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL clr_empty: rd_valid=%b, expected 0", rd_valid);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 17; i++)
         push_byte(8'(8'h50 + i));
      rd_ready = 1'b1;
      for (int i = 0; i < 11; i++)
         tick();
      rd_ready = 1'b0;
      checks++;
      if (count !== 5'd5 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset: count=%0d overflow=%b, expected 5/1", count, overflow);
      end
      rx_toggle = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (count !== 5'd0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: count=%0d rd_valid=%b overflow=%b, expected 0/0/0",
                  count, rd_valid, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (count !== 5'd0) begin
         failures++;
         $display("FAIL reprime: count=%0d, expected 0", count);
      end
      push_byte(8'h77);
      checks++;
      if (count !== 5'd1 || rd_data !== 8'h77) begin
         failures++;
         $display("FAIL post_reset_push: count=%0d rd_data=%h, expected 1/77", count, rd_data);
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      rd_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(8'h80 + i - 1)) begin
               failures++;
               $display("FAIL wrap[%0d]: rd_valid=%b rd_data=%h, expected 1/%h",
                        i, rd_valid, rd_data, 8'(8'h80 + i - 1));
            end
         end
         push_byte(8'(8'h80 + i));
      end
      checks++;
      if (count !== 5'd1 || rd_data !== 8'hA7) begin
         failures++;
         $display("FAIL wrap_last: count=%0d rd_data=%h, expected 1/a7", count, rd_data);
      end
      tick();
      rd_ready = 1'b0;
      checks++;
      if (count !== 5'd0 || rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL wrap_empty: count=%0d rd_valid=%b, expected 0/0", count, rd_valid);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      rx_toggle      = 1'b1;
      rx_data        = 8'h00;
      rd_ready       = 1'b0;
      clear_overflow = 1'b0;
      test_reset();
      test_fwft_order();
      test_overflow();
      test_full_push_pop();
      test_clear_vs_drop();
      test_async_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
